uart_word_bridge: RTL and testbench
===================================

# uart_word_bridge

Word-level bridge between a byte-wide UART core and the command interpreter. It assembles received bytes into 32-bit little-endian words and buffers them in a small FIFO, which the interpreter drains via its read handshake. It also serializes 32-bit response words from the interpreter into four bytes for the UART transmitter. It answers the interpreter's `uart_read`/`uart_write` requests with single-cycle `uart_read_response`/`uart_write_response` pulses.

## Interface
- `RX_FIFO_DEPTH`, 8: RX word FIFO entries. Must be a power of two, ≥2.
- `BYTE_TIMEOUT_CYCLES`, 4096: idle cycles after which a partially assembled RX word is discarded. 0 disables the timeout.
- `clk`  in  1  system clock; every register is clocked on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx_byte_valid`  in  1  one-cycle strobe: `rx_byte` holds a received byte.
- `rx_byte`  in  8  received byte.
- `tx_byte_ready`  in  1  byte transmitter can accept a byte.
- `tx_byte_valid`  out  1  `tx_byte` is valid. Held until accepted.
- `tx_byte`  out  8  byte to transmit.
- `uart_rx_empty`  out  1  RX FIFO holds no complete word.
- `uart_tx_empty`  out  1  TX serializer idle.
- `uart_read`  in  1  interpreter read request (level, may stay high after response).
- `uart_read_response`  out  1  one-cycle pulse: `uart_read_data` is valid.
- `uart_read_data`  out  32  popped word. Holds its value until the next pop.
- `uart_write`  in  1  interpreter write request (one-cycle pulse).
- `uart_write_data`  in  32  word to send. Sampled with `uart_write`.
- `uart_write_response`  out  1  one-cycle pulse: all 4 bytes were accepted.
- `rx_overflow`  out  1  sticky: a completed word was dropped because the FIFO was full.

## Operation
- **RX assembler**
  - 2-bit byte index plus a 24-bit shift register.
  - The first byte goes to bits [7:0], the fourth to [31:24].
  - On the 4th byte, the assembled word is pushed to the FIFO and the index returns to 0.
- **RX timeout**
  - Active only when the byte index is nonzero.
  - An idle counter increments each cycle without `rx_byte_valid` and clears on every byte.
  - When it reaches `BYTE_TIMEOUT_CYCLES`, the byte index and counter reset and the partial bytes are discarded.
  - A byte arriving in the same cycle the timeout fires is kept as byte 0 of a new word.
- **FIFO**
  - Pointers of log2(depth) bits that wrap naturally, plus a count of log2(depth)+1 bits.
  - `uart_rx_empty = (count == 0)`.
- **Overflow**
  - A push when full, with no pop in the same cycle, drops the word and sets `rx_overflow`. The FIFO is unchanged.
  - A push and a pop in the same cycle while full both take effect: count is unchanged and there is no overflow.
- **Read handshake** (states: ARMED, WAIT_LOW)
  - In ARMED, with `uart_read` high and count > 0: pop the head into `uart_read_data`, pulse `uart_read_response`, and go to WAIT_LOW.
  - In ARMED, with `uart_read` high and count = 0: the request stays pending. The pop occurs on the first edge where count > 0, and a word completing at edge E is poppable from edge E+1.
  - In WAIT_LOW, `uart_read` is ignored until it is sampled low. Then return to ARMED. This guarantees exactly one pop per request.
- **TX serializer** (states: TX_IDLE, TX_SEND)
  - In TX_IDLE, `uart_write` latches `uart_write_data` and sets the byte index to 0. Go to TX_SEND.
  - In TX_SEND, `tx_byte_valid` = 1 and `tx_byte` = word[8·i+7 : 8·i].
  - A byte is accepted on an edge where `tx_byte_valid` and `tx_byte_ready` are both high.
  - After acceptance of byte 3: pulse `uart_write_response`, return to TX_IDLE.
  - `uart_tx_empty` = 1 exactly in TX_IDLE.
  - `uart_write` during TX_SEND is ignored: no latch and no extra response.

## Timing
- **Reset values**: `uart_rx_empty`=1, `uart_tx_empty`=1. All other outputs are 0.
  - FIFO emptied, byte index 0, read FSM ARMED, TX FSM TX_IDLE.
  - Reset mid-operation discards partial words, FIFO contents and any in-flight TX word. No response pulse is issued.
- **RX latency**: with the 4th byte sampled at edge E, `uart_rx_empty` falls in the cycle after E.
- **Read latency**: with `uart_read` sampled high at edge E (ARMED, count > 0), `uart_read_response` and the new `uart_read_data` are valid in the cycle after E, for exactly one cycle. `uart_rx_empty` updates in that same cycle.
- **Read throughput**: a new pop requires `uart_read` to be sampled low first.
- **Write latency**: with `uart_write` sampled at E, `tx_byte_valid` is high from E+1.
  - With `tx_byte_ready` held high, the bytes are accepted at E+1..E+4.
  - `uart_write_response` and `uart_tx_empty`=1 are valid in the cycle after E+4.
  - Each low cycle of `tx_byte_ready` adds one cycle. `tx_byte` is stable while not accepted.
- RX, read and TX paths operate concurrently and independently.

## Test plan
- **Read one word**: bytes 0x70,0x00,0x00,0x00 → `uart_rx_empty` falls. Hold `uart_read` high 3 cycles → exactly one response with `uart_read_data`=0x00000070. `uart_rx_empty`=1 afterwards.
- **Write one word**: `uart_write` pulse with 0x7700006A, `tx_byte_ready` toggling 1,0,1,… → bytes 6A,00,00,77 in order. One `uart_write_response` after the last acceptance. `uart_tx_empty` low throughout.
- **Overflow**: push 9 words (0x1..0x9) with depth 8 and no reads → `rx_overflow`=1. Reads return 0x1..0x8, then `uart_rx_empty`=1.
- **Pending read**: `uart_read` high on an empty FIFO, then bytes 0xEF,0xBE,0xAD,0xDE → response 2 cycles after the 4th byte with data 0xDEADBEEF.
- **Timeout resync**: `BYTE_TIMEOUT_CYCLES`=16; send 2 bytes, idle 20 cycles, then bytes 01,02,03,04 → a single word 0x04030201.
- **Reset**: assert `reset_n` low during TX byte 2 with 2 words queued → all outputs at reset values immediately, no response pulse, FIFO empty.

Source files
------------

// File: rtl/uart_word_bridge_if.sv
// Interpreter-side and byte-side signals of the UART word bridge.
// No logic inside: a pure bundle of nets.
// The slave modport is the bridge's view; master is the surrounding system.
interface uart_word_bridge_if;
    // byte-side UART core signals
    logic        rx_byte_valid;
    logic [7:0]  rx_byte;
    logic        tx_byte_ready;
    logic        tx_byte_valid;
    logic [7:0]  tx_byte;
    logic        rx_overflow;
    // interpreter-side word signals
    logic        uart_rx_empty;
    logic        uart_tx_empty;
    logic        uart_read;
    logic        uart_read_response;
    logic [31:0] uart_read_data;
    logic        uart_write;
    logic [31:0] uart_write_data;
    logic        uart_write_response;

    modport slave (
        input  rx_byte_valid, rx_byte, tx_byte_ready,
        input  uart_read, uart_write, uart_write_data,
        output tx_byte_valid, tx_byte, rx_overflow,
        output uart_rx_empty, uart_tx_empty,
        output uart_read_response, uart_read_data, uart_write_response
    );

    modport master (
        output rx_byte_valid, rx_byte, tx_byte_ready,
        output uart_read, uart_write, uart_write_data,
        input  tx_byte_valid, tx_byte, rx_overflow,
        input  uart_rx_empty, uart_tx_empty,
        input  uart_read_response, uart_read_data, uart_write_response
    );
endinterface

// File: rtl/uart_word_bridge.sv
// Assembles RX bytes into LE 32-bit words (FIFO-buffered) and serializes TX words into 4 bytes.
// Latency: word poppable 1 cycle after 4th byte; read response 1 cycle after request; first TX byte 1 cycle after write.
// Backpressure: TX byte held until tx_byte_ready; RX words dropped (sticky rx_overflow) when FIFO full with no pop.
module uart_word_bridge #(
    parameter int RX_FIFO_DEPTH       = 8,
    parameter int BYTE_TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               reset_n,
    uart_word_bridge_if.slave  bus
);
    localparam int AW = $clog2(RX_FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (BYTE_TIMEOUT_CYCLES > 0) ? $clog2(BYTE_TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(RX_FIFO_DEPTH);
    localparam logic [TW-1:0] TO_CNT   = TW'(BYTE_TIMEOUT_CYCLES);

    typedef enum logic {RD_ARMED, RD_WAIT_LOW} rd_state_t;
    typedef enum logic {TX_IDLE, TX_SEND}      tx_state_t;

    // RX assembler state
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [23:0]   shreg_q, shreg_d;
    logic [TW-1:0] idle_cnt_q, idle_cnt_d;
    logic          timeout_fire;
    logic          word_done;
    logic [31:0]   word_dat;

    // FIFO state
    logic [31:0]   mem_q [RX_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          rx_overflow_q, rx_overflow_d;

    // read handshake state
    rd_state_t     rd_state_q, rd_state_d;
    logic          rd_pop;
    logic          read_resp_q, read_resp_d;
    logic [31:0]   read_data_q, read_data_d;

    // TX serializer state
    tx_state_t     tx_state_q, tx_state_d;
    logic [31:0]   tx_word_q, tx_word_d;
    logic [1:0]    tx_idx_q, tx_idx_d;
    logic          write_resp_q, write_resp_d;

    // RX byte assembly with idle timeout; a byte in the timeout cycle starts a fresh word
    always_comb begin
        timeout_fire = (BYTE_TIMEOUT_CYCLES != 0) && (byte_idx_q != 2'd0) && (idle_cnt_q == TO_CNT);
        byte_idx_d   = byte_idx_q;
        shreg_d      = shreg_q;
        idle_cnt_d   = idle_cnt_q;
        word_done    = 1'b0;
        word_dat     = {bus.rx_byte, shreg_q};
        if (bus.rx_byte_valid) begin
            // bytes shift in from the top so the first byte lands in [7:0] after three shifts
            shreg_d    = {bus.rx_byte, shreg_q[23:8]};
            idle_cnt_d = '0;
            if (timeout_fire) begin
                byte_idx_d = 2'd1;
            end else begin
                byte_idx_d = byte_idx_q + 2'd1;
                word_done  = (byte_idx_q == 2'd3);
            end
        end else if (timeout_fire) begin
            byte_idx_d = 2'd0;
            idle_cnt_d = '0;
        end else if (byte_idx_q != 2'd0) begin
            idle_cnt_d = idle_cnt_q + TW'(1);
        end
    end

    // Read handshake: one pop per request, re-armed only after uart_read is seen low
    always_comb begin
        rd_state_d  = rd_state_q;
        rd_pop      = 1'b0;
        read_resp_d = 1'b0;
        read_data_d = read_data_q;
        case (rd_state_q)
            RD_ARMED: begin
                if (bus.uart_read && (count_q != '0)) begin
                    rd_pop      = 1'b1;
                    read_data_d = mem_q[rd_ptr_q];
                    read_resp_d = 1'b1;
                    rd_state_d  = RD_WAIT_LOW;
                end
            end
            RD_WAIT_LOW: begin
                if (!bus.uart_read) rd_state_d = RD_ARMED;
            end
            default: rd_state_d = RD_ARMED;
        endcase
    end

    // FIFO bookkeeping; a simultaneous pop makes room for a push even when full
    always_comb begin
        push_ok       = word_done && ((count_q != FULL_CNT) || rd_pop);
        rx_overflow_d = rx_overflow_q | (word_done && (count_q == FULL_CNT) && !rd_pop);
        wr_ptr_d      = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d      = rd_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d       = count_q;
        if (push_ok && !rd_pop)      count_d = count_q + CW'(1);
        else if (!push_ok && rd_pop) count_d = count_q - CW'(1);
    end

    // TX serializer: latch a word when idle, then hand out bytes LSB first
    always_comb begin
        tx_state_d   = tx_state_q;
        tx_word_d    = tx_word_q;
        tx_idx_d     = tx_idx_q;
        write_resp_d = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (bus.uart_write) begin
                    tx_word_d  = bus.uart_write_data;
                    tx_idx_d   = 2'd0;
                    tx_state_d = TX_SEND;
                end
            end
            TX_SEND: begin
                if (bus.tx_byte_ready) begin
                    if (tx_idx_q == 2'd3) begin
                        write_resp_d = 1'b1;
                        tx_state_d   = TX_IDLE;
                    end else begin
                        tx_idx_d = tx_idx_q + 2'd1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // State registers for all three paths
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_idx_q    <= 2'd0;
            shreg_q       <= '0;
            idle_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            rx_overflow_q <= 1'b0;
            rd_state_q    <= RD_ARMED;
            read_resp_q   <= 1'b0;
            read_data_q   <= '0;
            tx_state_q    <= TX_IDLE;
            tx_word_q     <= '0;
            tx_idx_q      <= 2'd0;
            write_resp_q  <= 1'b0;
        end else begin
            byte_idx_q    <= byte_idx_d;
            shreg_q       <= shreg_d;
            idle_cnt_q    <= idle_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            rx_overflow_q <= rx_overflow_d;
            rd_state_q    <= rd_state_d;
            read_resp_q   <= read_resp_d;
            read_data_q   <= read_data_d;
            tx_state_q    <= tx_state_d;
            tx_word_q     <= tx_word_d;
            tx_idx_q      <= tx_idx_d;
            write_resp_q  <= write_resp_d;
        end
    end

    // FIFO storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= word_dat;
    end

    assign bus.uart_rx_empty       = (count_q == '0);
    assign bus.uart_tx_empty       = (tx_state_q == TX_IDLE);
    assign bus.tx_byte_valid       = (tx_state_q == TX_SEND);
    assign bus.tx_byte             = (tx_state_q == TX_SEND) ? tx_word_q[{tx_idx_q, 3'b000} +: 8] : 8'h00;
    assign bus.uart_read_response  = read_resp_q;
    assign bus.uart_read_data      = read_data_q;
    assign bus.uart_write_response = write_resp_q;
    assign bus.rx_overflow         = rx_overflow_q;
endmodule

// File: tb/tb_uart_word_bridge.sv
// Directed bench for uart_word_bridge: RX assembly, read handshake, TX serializer,
// overflow, pending read, byte timeout and mid-operation reset.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_word_bridge;
    logic clk;
    logic reset_n;
    int   n_chk;
    int   n_fail;

    uart_word_bridge_if bif ();

    uart_word_bridge #(
        .RX_FIFO_DEPTH      (8),
        .BYTE_TIMEOUT_CYCLES(16)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // one byte strobe; caller is at a falling edge and returns at the next one
    task automatic send_byte(input logic [7:0] b);
        bif.rx_byte_valid = 1'b1;
        bif.rx_byte       = b;
        @(negedge clk);
        bif.rx_byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] t;
            t = w >> (8 * k);
            send_byte(t[7:0]);
        end
    endtask

    // raise uart_read, wait (bounded) for the response, then drop the request
    task automatic read_word(input string tag, input logic [31:0] exp);
        logic        got;
        logic [31:0] d;
        got = 1'b0;
        d   = 32'hFFFF_FFFF;
        bif.uart_read = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (bif.uart_read_response) begin
                got = 1'b1;
                d   = bif.uart_read_data;
            end
        end
        bif.uart_read = 1'b0;
        @(negedge clk);
        chk(tag, d, exp);
    endtask

    initial begin
        int          n;
        int          nacc;
        bit          r;
        bit          busy_ok;
        logic [7:0]  got_b [4];

        n_chk  = 0;
        n_fail = 0;
        reset_n = 1'b0;
        bif.rx_byte_valid   = 1'b0;
        bif.rx_byte         = 8'h00;
        bif.tx_byte_ready   = 1'b0;
        bif.uart_read       = 1'b0;
        bif.uart_write      = 1'b0;
        bif.uart_write_data = 32'h0;
        repeat (3) @(negedge clk);

        // reset values
        chk("rst_rx_empty",  bif.uart_rx_empty, 1);
        chk("rst_tx_empty",  bif.uart_tx_empty, 1);
        chk("rst_tx_valid",  bif.tx_byte_valid, 0);
        chk("rst_rd_resp",   bif.uart_read_response, 0);
        chk("rst_wr_resp",   bif.uart_write_response, 0);
        chk("rst_overflow",  bif.rx_overflow, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // read one word, request held for three cycles
        send_word(32'h0000_0070);
        chk("rx_empty_fall", bif.uart_rx_empty, 0);
        bif.uart_read = 1'b1;
        n = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bif.uart_read_response) n++;
            if (k == 0) chk("rd_latency", bif.uart_read_response, 1);
            if (k == 0) chk("rd_data", bif.uart_read_data, 32'h0000_0070);
        end
        bif.uart_read = 1'b0;
        @(negedge clk);
        if (bif.uart_read_response) n++;
        chk("rd_once", n, 1);
        chk("rx_empty_after_rd", bif.uart_rx_empty, 1);

        // write one word with tx_byte_ready toggling; a second write mid-stream is ignored
        bif.uart_write_data = 32'h7700_006A;
        bif.uart_write      = 1'b1;
        @(negedge clk);
        bif.uart_write = 1'b0;
        chk("tx_vld_latency", bif.tx_byte_valid, 1);
        r = 1'b1;
        nacc = 0;
        busy_ok = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && nacc < 4; c++) begin
            if (bif.uart_tx_empty !== 1'b0) busy_ok = 1'b0;
            if (bif.uart_write_response) n++;
            if (c == 2) begin
                bif.uart_write      = 1'b1;
                bif.uart_write_data = 32'h1111_1111;
            end else begin
                bif.uart_write = 1'b0;
            end
            bif.tx_byte_ready = r;
            if (bif.tx_byte_valid && r) begin
                got_b[nacc] = bif.tx_byte;
                nacc++;
            end
            r = !r;
            @(negedge clk);
        end
        bif.tx_byte_ready = 1'b0;
        bif.uart_write    = 1'b0;
        chk("tx_nbytes", nacc, 4);
        chk("tx_b0", got_b[0], 8'h6A);
        chk("tx_b1", got_b[1], 8'h00);
        chk("tx_b2", got_b[2], 8'h00);
        chk("tx_b3", got_b[3], 8'h77);
        chk("tx_busy", busy_ok, 1);
        chk("wr_resp_early", n, 0);
        chk("wr_resp", bif.uart_write_response, 1);
        chk("tx_empty_end", bif.uart_tx_empty, 1);
        n = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bif.uart_write_response) n++;
        end
        chk("wr_resp_once", n, 0);
        chk("tx_idle_after", bif.uart_tx_empty, 1);

        // overflow: nine words into depth eight
        for (int i = 1; i <= 8; i++) send_word(i);
        chk("ovf_before", bif.rx_overflow, 0);
        send_word(32'd9);
        chk("ovf_set", bif.rx_overflow, 1);
        for (int i = 1; i <= 8; i++) read_word($sformatf("ovf_rd%0d", i), i);
        chk("ovf_drained", bif.uart_rx_empty, 1);

        // pending read on an empty FIFO
        bif.uart_read = 1'b1;
        n = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bif.uart_read_response) n++;
        end
        chk("pend_no_resp", n, 0);
        send_word(32'hDEAD_BEEF);
        chk("pend_resp_e1", bif.uart_read_response, 0);
        @(negedge clk);
        chk("pend_resp_e2", bif.uart_read_response, 1);
        chk("pend_data", bif.uart_read_data, 32'hDEAD_BEEF);
        bif.uart_read = 1'b0;
        @(negedge clk);

        // timeout resync: two stray bytes, long idle, then a clean word
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (20) @(negedge clk);
        send_word(32'h0403_0201);
        chk("to_rx_ready", bif.uart_rx_empty, 0);
        read_word("to_word", 32'h0403_0201);
        chk("to_single", bif.uart_rx_empty, 1);

        // reset during TX byte 2 with two words queued
        send_word(32'hCAFE_0001);
        send_word(32'hCAFE_0002);
        chk("rst_pre_rx", bif.uart_rx_empty, 0);
        bif.uart_write_data = 32'hA1B2_C3D4;
        bif.uart_write      = 1'b1;
        bif.tx_byte_ready   = 1'b1;
        @(negedge clk);
        bif.uart_write = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pre_txb", bif.tx_byte, 8'hB2);
        #2 reset_n = 1'b0;
        #1;
        chk("rst2_rx_empty", bif.uart_rx_empty, 1);
        chk("rst2_tx_empty", bif.uart_tx_empty, 1);
        chk("rst2_tx_valid", bif.tx_byte_valid, 0);
        chk("rst2_tx_byte",  bif.tx_byte, 0);
        chk("rst2_rd_data",  bif.uart_read_data, 0);
        chk("rst2_overflow", bif.rx_overflow, 0);
        chk("rst2_wr_resp",  bif.uart_write_response, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bif.uart_write_response || bif.tx_byte_valid) n++;
        end
        bif.tx_byte_ready = 1'b0;
        chk("rst2_no_tx_activity", n, 0);
        chk("rst2_fifo_empty", bif.uart_rx_empty, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
